// File: rtl/inout_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : inout_bus_responder
// Description : Responder end of a half-duplex shared inout data bus. Holds a
//               DEPTH x DW register bank reachable from the bus (read/write)
//               and from a local write port. Drives bus_dq only during its
//               single read-data beat.
// Revision    : 1.0 - initial release
// ============================================================================
module inout_bus_responder #(
    parameter  int DW     = 8,
    parameter  int ADDR_W = 2,
    localparam int DEPTH  = 2 ** ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bus_req,
    input  logic                  bus_wr,
    inout  wire  [DW-1:0]         bus_dq,
    output logic                  bus_ack,
    output logic                  bus_oe,
    output logic                  bus_wr_stb,
    output logic [ADDR_W-1:0]     bus_wr_addr,
    input  logic                  loc_we,
    input  logic [ADDR_W-1:0]     loc_addr,
    input  logic [DW-1:0]         loc_wdata,
    output logic [DEPTH*DW-1:0]   reg_q
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WDATA    = 3'd1,
        S_TURN     = 3'd2,
        S_RDATA    = 3'd3,
        S_WAIT_REL = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DW-1:0]       r_rdata;

    // The bus is released whenever the registered drive enable is low; since
    // bus_oe is cleared asynchronously, reset releases the bus immediately.
    assign bus_dq = bus_oe ? r_rdata : {DW{1'bz}};

    // Transaction FSM plus register bank. The local write is placed before the
    // bus write so that the bus write wins when both target the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_rdata     <= '0;
            bus_ack     <= 1'b0;
            bus_oe      <= 1'b0;
            bus_wr_stb  <= 1'b0;
            bus_wr_addr <= '0;
            reg_q       <= '0;
        end else begin
            bus_ack    <= 1'b0;
            bus_wr_stb <= 1'b0;

            if (loc_we) begin
                reg_q[int'(loc_addr)*DW +: DW] <= loc_wdata;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus_req) begin
                        r_addr  <= bus_dq[ADDR_W-1:0];
                        r_state <= bus_wr ? S_WDATA : S_TURN;
                    end
                end
                S_WDATA: begin
                    if (bus_req) begin
                        reg_q[int'(r_addr)*DW +: DW] <= bus_dq;
                        bus_ack     <= 1'b1;
                        bus_wr_stb  <= 1'b1;
                        bus_wr_addr <= r_addr;
                        r_state     <= S_WAIT_REL;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_TURN: begin
                    if (bus_req) begin
                        // Sampled before this edge's writes land: a same-edge
                        // local write is not visible in this beat.
                        r_rdata <= reg_q[int'(r_addr)*DW +: DW];
                        bus_oe  <= 1'b1;
                        bus_ack <= 1'b1;
                        r_state <= S_RDATA;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RDATA: begin
                    // Single beat; completes regardless of bus_req.
                    bus_oe  <= 1'b0;
                    r_state <= S_WAIT_REL;
                end
                S_WAIT_REL: begin
                    if (!bus_req) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    bus_oe  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inout_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inout_bus_responder
// Description : Self-checking bench for inout_bus_responder. Directed steps
//               followed by randomized transactions against a bank model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inout_bus_responder;

    logic        clk;
    logic        rst_n;
    logic        bus_req;
    logic        bus_wr;
    wire  [7:0]  bus_dq;
    logic        bus_ack;
    logic        bus_oe;
    logic        bus_wr_stb;
    logic [1:0]  bus_wr_addr;
    logic        loc_we;
    logic [1:0]  loc_addr;
    logic [7:0]  loc_wdata;
    logic [31:0] reg_q;

    logic        tb_oe;
    logic [7:0]  tb_drv;

    int vectors = 0;
    int errs    = 0;

    logic [7:0] mb [4];
    logic [1:0] last_wr_addr;

    assign bus_dq = tb_oe ? tb_drv : 8'bz;

    inout_bus_responder #(.DW(8), .ADDR_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .bus_wr(bus_wr),
        .bus_dq(bus_dq), .bus_ack(bus_ack), .bus_oe(bus_oe),
        .bus_wr_stb(bus_wr_stb), .bus_wr_addr(bus_wr_addr),
        .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
        .reg_q(reg_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_q();
        return {mb[3], mb[2], mb[1], mb[0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; the model applies any pending local write at the edge.
    task automatic tick();
        logic       we;
        logic [1:0] a;
        logic [7:0] d;
        we = loc_we; a = loc_addr; d = loc_wdata;
        @(posedge clk);
        #1;
        if (we) mb[a] = d;
        loc_we = 1'b0;
        chk("contention", {63'd0, tb_oe && bus_oe}, 64'd0);
    endtask

    task automatic set_loc(input logic we, input logic [1:0] a, input logic [7:0] d);
        loc_we = we; loc_addr = a; loc_wdata = d;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input logic abort,
                             input logic lwe, input logic [1:0] la, input logic [7:0] ld);
        bus_req = 1'b1; bus_wr = 1'b1; tb_oe = 1'b1;
        tb_drv  = {6'($urandom), a};
        tick();
        chk("wr_ack_early", {63'd0, bus_ack}, 64'd0);
        chk("wr_stb_early", {63'd0, bus_wr_stb}, 64'd0);
        tb_drv = d;
        if (abort) bus_req = 1'b0;
        set_loc(lwe, la, ld);
        tick();
        if (abort) begin
            chk("wr_abort_ack", {63'd0, bus_ack}, 64'd0);
            chk("wr_abort_stb", {63'd0, bus_wr_stb}, 64'd0);
        end else begin
            mb[a] = d;
            last_wr_addr = a;
            chk("wr_ack", {63'd0, bus_ack}, 64'd1);
            chk("wr_stb", {63'd0, bus_wr_stb}, 64'd1);
        end
        chk("wr_addr", {62'd0, bus_wr_addr}, {62'd0, last_wr_addr});
        chk("wr_regq", {32'd0, reg_q}, {32'd0, exp_q()});
        tb_oe = 1'b0;
        if (!abort) begin
            bus_req = 1'b0;
            tick();
            chk("wr_ack_pulse", {63'd0, bus_ack}, 64'd0);
            chk("wr_stb_pulse", {63'd0, bus_wr_stb}, 64'd0);
        end
    endtask

    task automatic bus_read(input logic [1:0] a, input logic abort, input logic drop_in_rdata,
                            input logic lwe, input logic [1:0] la, input logic [7:0] ld);
        logic [7:0] expv;
        bus_req = 1'b1; bus_wr = 1'b0; tb_oe = 1'b1;
        tb_drv  = {6'($urandom), a};
        tick();
        tb_oe = 1'b0;
        chk("rd_turn_oe", {63'd0, bus_oe}, 64'd0);
        chk("rd_turn_ack", {63'd0, bus_ack}, 64'd0);
        expv = mb[a];
        if (abort) bus_req = 1'b0;
        set_loc(lwe, la, ld);
        tick();
        if (abort) begin
            chk("rd_abort_oe", {63'd0, bus_oe}, 64'd0);
            chk("rd_abort_ack", {63'd0, bus_ack}, 64'd0);
            return;
        end
        chk("rd_oe", {63'd0, bus_oe}, 64'd1);
        chk("rd_ack", {63'd0, bus_ack}, 64'd1);
        chk("rd_data", {56'd0, bus_dq}, {56'd0, expv});
        chk("rd_stb", {63'd0, bus_wr_stb}, 64'd0);
        if (drop_in_rdata) bus_req = 1'b0;
        tick();
        chk("rd_release_oe", {63'd0, bus_oe}, 64'd0);
        chk("rd_ack_pulse", {63'd0, bus_ack}, 64'd0);
        bus_req = 1'b0;
        tick();
        chk("rd_idle_ack", {63'd0, bus_ack}, 64'd0);
        chk("rd_regq", {32'd0, reg_q}, {32'd0, exp_q()});
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] a;
        rst_n = 1'b0; bus_req = 1'b0; bus_wr = 1'b0; tb_oe = 1'b0; tb_drv = '0;
        loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
        for (int i = 0; i < 4; i++) mb[i] = '0;
        last_wr_addr = '0;

        // Reset state with the bus floating
        repeat (2) @(posedge clk);
        #1;
        chk("rst_oe", {63'd0, bus_oe}, 64'd0);
        chk("rst_ack", {63'd0, bus_ack}, 64'd0);
        chk("rst_stb", {63'd0, bus_wr_stb}, 64'd0);
        chk("rst_wr_addr", {62'd0, bus_wr_addr}, 64'd0);
        chk("rst_regq", {32'd0, reg_q}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Bus write of A5 to address 2, then read it back
        bus_write(2'd2, 8'hA5, 1'b0, 1'b0, 2'd0, 8'h00);
        chk("t2_byte2", {56'd0, reg_q[23:16]}, 64'hA5);
        bus_read(2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);

        // Collision: bus wins on same address; different address both land
        bus_write(2'd1, 8'h11, 1'b0, 1'b1, 2'd1, 8'h22);
        chk("t4_byte1", {56'd0, reg_q[15:8]}, 64'h11);
        bus_write(2'd1, 8'h33, 1'b0, 1'b1, 2'd3, 8'h44);
        chk("t4_byte3", {56'd0, reg_q[31:24]}, 64'h44);
        chk("t4_byte1b", {56'd0, reg_q[15:8]}, 64'h33);

        // Same-edge local write during a read returns the old value
        bus_read(2'd3, 1'b0, 1'b1, 1'b1, 2'd3, 8'h5C);
        chk("t4_rd_new", {56'd0, reg_q[31:24]}, 64'h5C);

        // Abort in WDATA, immediately followed by an accepted transaction
        bus_write(2'd0, 8'hEE, 1'b1, 1'b0, 2'd0, 8'h00);
        chk("t5_byte0", {56'd0, reg_q[7:0]}, 64'h00);
        bus_write(2'd0, 8'h7B, 1'b0, 1'b0, 2'd0, 8'h00);
        chk("t5_next", {56'd0, reg_q[7:0]}, 64'h7B);

        // Back-to-back: request held after ack must not start a second one
        bus_req = 1'b1; bus_wr = 1'b1; tb_oe = 1'b1; tb_drv = 8'h03;
        tick();
        tb_drv = 8'h9D;
        tick();
        mb[3] = 8'h9D; last_wr_addr = 2'd3;
        chk("t6_ack", {63'd0, bus_ack}, 64'd1);
        bus_wr = 1'b0; tb_drv = 8'h02;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_hold_ack", {63'd0, bus_ack}, 64'd0);
            chk("t6_hold_oe", {63'd0, bus_oe}, 64'd0);
        end
        tb_oe = 1'b0; bus_req = 1'b0;
        tick();
        bus_read(2'd3, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        chk("t6_wr_addr", {62'd0, bus_wr_addr}, 64'd3);

        // Read abort in TURN
        bus_read(2'd1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        tick();

        // Randomized transactions against the bank model
        for (int n = 0; n < 60; n++) begin
            a = 2'($urandom);
            d = 8'($urandom);
            if ($urandom_range(1, 0) == 1)
                bus_write(a, d, $urandom_range(3, 0) == 0, 1'($urandom),
                          2'($urandom), 8'($urandom));
            else
                bus_read(a, $urandom_range(3, 0) == 0, 1'($urandom), 1'($urandom),
                         2'($urandom), 8'($urandom));
            if ($urandom_range(1, 0) == 1) begin
                set_loc(1'b1, 2'($urandom), 8'($urandom));
                tick();
            end
            chk("rand_regq", {32'd0, reg_q}, {32'd0, exp_q()});
        end

        // Asynchronous reset asserted in the middle of a read beat
        bus_write(2'd0, 8'hC3, 1'b0, 1'b0, 2'd0, 8'h00);
        bus_req = 1'b1; bus_wr = 1'b0; tb_oe = 1'b1; tb_drv = 8'h00;
        tick();
        tb_oe = 1'b0;
        tick();
        chk("t1_rdata_oe", {63'd0, bus_oe}, 64'd1);
        chk("t1_rdata_dq", {56'd0, bus_dq}, 64'hC3);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) mb[i] = '0;
        chk("t1_async_oe", {63'd0, bus_oe}, 64'd0);
        chk("t1_async_ack", {63'd0, bus_ack}, 64'd0);
        chk("t1_async_regq", {32'd0, reg_q}, 64'd0);
        chk("t1_async_wr_addr", {62'd0, bus_wr_addr}, 64'd0);
        bus_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        last_wr_addr = 2'd0;
        bus_read(2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
